fetch_decode_stage: RTL and testbench
=====================================

Name: fetch_decode_stage

Overview:
- Fetch stage plus IF/ID pipeline register for the pipelined ARM core.
- Sits directly upstream of the hazard unit and the Decode stage, and consumes that unit's StallF, StallD and FlushD.
- Owns the PC register and the next-PC selection (sequential, branch redirect from Execute, PC write from Writeback).
- Registers the fetched instruction into Decode and keeps saturating fetch/stall/flush event counters for debug.

Parameters:
- WIDTH, 32, datapath/address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_WIDTH, 16, width of each debug event counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- StallF  input  1  hold the PC register.
- StallD  input  1  hold the IF/ID register.
- FlushD  input  1  bubble the IF/ID register.
- BranchTakenE  input  1  branch resolved taken in Execute.
- ALUResultE  input  WIDTH  branch target from Execute.
- PCSrcW  input  1  Writeback instruction writes R15.
- ResultW  input  WIDTH  Writeback result (new PC).
- InstrF  input  32  instruction-memory read data, combinational from PCF.
- PCF  output  WIDTH  current fetch address, drives instruction memory.
- InstrD  output  32  registered instruction for Decode.
- PCD  output  WIDTH  registered PC of InstrD.
- PCPlus8D  output  WIDTH  PCD+8, the architectural R15 read value.
- ValidD  output  1  InstrD is a real instruction (0 = bubble).
- FetchCnt  output  CNT_WIDTH  cycles in which PCF advanced.
- StallCnt  output  CNT_WIDTH  cycles with StallF high and no redirect.
- FlushCnt  output  CNT_WIDTH  cycles with FlushD high.

Behaviour:
- Reset (async, high): PCF=RESET_PC; InstrD=0, PCD=0, ValidD=0; all counters=0. Takes effect immediately, mid-operation included. The first fetch is from RESET_PC on the first edge after deassertion.
- PCPlus4F = PCF+4. PCPlus8D = PCD+8, combinational. Arithmetic wraps modulo 2^WIDTH, so PCF=32'hFFFF_FFFC advances to 0.
- Next PC, per rising edge, in priority order:
  1. BranchTakenE → ALUResultE
  2. else PCSrcW → ResultW
  3. else StallF → hold PCF
  4. else PCPlus4F
- A redirect (BranchTakenE or PCSrcW) overrides StallF. When both redirects are high, BranchTakenE wins.
- Redirect latency: the target appears on PCF one cycle after the redirect edge condition.
- IF/ID register, per rising edge, in priority order:
  1. FlushD → InstrD=0, PCD=0, ValidD=0
  2. else StallD → hold all three
  3. else InstrD=InstrF, PCD=PCF, ValidD=1
- FlushD overrides StallD.
- Redirect does not itself flush IF/ID; the hazard unit's FlushD is the only bubble source.
- InstrF is sampled with no handshake; instruction memory has zero wait states.
- Counters, each incrementing by 1 per qualifying edge and saturating at all-ones (no wrap):
  - FetchCnt: the PC register loaded any value other than hold (cases 1, 2, 4).
  - StallCnt: case 3 taken.
  - FlushCnt: FlushD high.
- There is no state machine beyond the registers above. ValidD acts as the one-bit pipeline-occupancy state.

Test Plan:
- Reset then 4 free-running cycles, InstrF=mem[PCF/4] → PCF 0,4,8,C,10; InstrD lags one cycle; PCD=0 when InstrD=mem[0]; PCPlus8D=8; ValidD 0 then 1; FetchCnt=4.
- StallF=StallD=1 for 2 cycles at PCF=0x10 → PCF holds 0x10; InstrD/PCD hold 0x0C entries; StallCnt=2; FetchCnt unchanged.
- BranchTakenE=1, ALUResultE=0x100, with FlushD=1 and StallF=1 same cycle → next PCF=0x100, ValidD=0, InstrD=0; StallCnt not incremented; FlushCnt+1.
- BranchTakenE=1 (ALUResultE=0x200) and PCSrcW=1 (ResultW=0x300) simultaneously → PCF=0x200. Next cycle PCSrcW alone with ResultW=0x300 → PCF=0x300.
- FlushD=1 and StallD=1 together → InstrD=0, ValidD=0 (flush wins). PCF=32'hFFFF_FFFC free-running → wraps to 0. CNT_WIDTH=2 with 5 fetches → FetchCnt=3.
- Assert reset asynchronously mid-cycle after a redirect → PCF=RESET_PC, ValidD=0, counters 0 before the next edge.

Source files
------------

// File: rtl/fetch_decode_stage.sv
// Fetch stage with PC register, next-PC selection, the IF/ID pipeline
// register and saturating debug event counters.
module fetch_decode_stage #(
  parameter int unsigned        WIDTH     = 32,
  parameter logic [WIDTH-1:0]   RESET_PC  = '0,
  parameter int unsigned        CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 StallF,
  input  logic                 StallD,
  input  logic                 FlushD,
  input  logic                 BranchTakenE,
  input  logic [WIDTH-1:0]     ALUResultE,
  input  logic                 PCSrcW,
  input  logic [WIDTH-1:0]     ResultW,
  input  logic [31:0]          InstrF,
  output logic [WIDTH-1:0]     PCF,
  output logic [31:0]          InstrD,
  output logic [WIDTH-1:0]     PCD,
  output logic [WIDTH-1:0]     PCPlus8D,
  output logic                 ValidD,
  output logic [CNT_WIDTH-1:0] FetchCnt,
  output logic [CNT_WIDTH-1:0] StallCnt,
  output logic [CNT_WIDTH-1:0] FlushCnt
);

  localparam logic [WIDTH-1:0]     PC_INC4 = WIDTH'(4);
  localparam logic [WIDTH-1:0]     PC_INC8 = WIDTH'(8);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [WIDTH-1:0]     pcf_q, pcf_d;
  logic [31:0]          instrd_q, instrd_d;
  logic [WIDTH-1:0]     pcd_q, pcd_d;
  logic                 validd_q, validd_d;
  logic [CNT_WIDTH-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  logic [WIDTH-1:0]     pc_plus4;
  logic                 pc_advance;
  logic                 pc_stall;

  assign pc_plus4 = pcf_q + PC_INC4;

  // Next-PC selection: redirects take priority over a fetch stall.
  always_comb begin
    pcf_d      = pcf_q;
    pc_advance = 1'b1;
    pc_stall   = 1'b0;
    if (BranchTakenE) begin
      pcf_d = ALUResultE;
    end else if (PCSrcW) begin
      pcf_d = ResultW;
    end else if (StallF) begin
      pc_advance = 1'b0;
      pc_stall   = 1'b1;
    end else begin
      pcf_d = pc_plus4;
    end
  end

  // IF/ID next state: a flush bubbles even when Decode is stalled.
  always_comb begin
    instrd_d = instrd_q;
    pcd_d    = pcd_q;
    validd_d = validd_q;
    if (FlushD) begin
      instrd_d = '0;
      pcd_d    = '0;
      validd_d = 1'b0;
    end else if (!StallD) begin
      instrd_d = InstrF;
      pcd_d    = pcf_q;
      validd_d = 1'b1;
    end
  end

  // Saturating event counters: stick at all-ones instead of wrapping.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_advance && (fetch_cnt_q != '1)) fetch_cnt_d = fetch_cnt_q + CNT_ONE;
    if (pc_stall   && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (FlushD     && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcf_q       <= RESET_PC;
      instrd_q    <= '0;
      pcd_q       <= '0;
      validd_q    <= 1'b0;
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pcf_q       <= pcf_d;
      instrd_q    <= instrd_d;
      pcd_q       <= pcd_d;
      validd_q    <= validd_d;
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign PCF      = pcf_q;
  assign InstrD   = instrd_q;
  assign PCD      = pcd_q;
  assign PCPlus8D = pcd_q + PC_INC8;
  assign ValidD   = validd_q;
  assign FetchCnt = fetch_cnt_q;
  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Table-driven bench for fetch_decode_stage with an expected-value queue.
module tb_fetch_decode_stage;

  localparam logic [31:0] IKEY = 32'hE3A0_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0;
  logic        BranchTakenE = 1'b0, PCSrcW = 1'b0;
  logic [31:0] ALUResultE = '0, ResultW = '0;

  logic [31:0] InstrF, PCF, InstrD, PCD, PCPlus8D;
  logic        ValidD;
  logic [15:0] FetchCnt, StallCnt, FlushCnt;

  logic [31:0] InstrF_s, PCF_s, InstrD_s, PCD_s, PCPlus8D_s;
  logic        ValidD_s;
  logic [1:0]  FetchCnt_s, StallCnt_s, FlushCnt_s;

  // Instruction memory: word content derived from its address.
  assign InstrF   = PCF ^ IKEY;
  assign InstrF_s = PCF_s ^ IKEY;

  always #5 clk = ~clk;

  fetch_decode_stage dut (
    .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .BranchTakenE(BranchTakenE), .ALUResultE(ALUResultE), .PCSrcW(PCSrcW),
    .ResultW(ResultW), .InstrF(InstrF), .PCF(PCF), .InstrD(InstrD), .PCD(PCD),
    .PCPlus8D(PCPlus8D), .ValidD(ValidD), .FetchCnt(FetchCnt),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  fetch_decode_stage #(.WIDTH(32), .RESET_PC(32'h0000_0080), .CNT_WIDTH(2)) dut_s (
    .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .BranchTakenE(BranchTakenE), .ALUResultE(ALUResultE), .PCSrcW(PCSrcW),
    .ResultW(ResultW), .InstrF(InstrF_s), .PCF(PCF_s), .InstrD(InstrD_s), .PCD(PCD_s),
    .PCPlus8D(PCPlus8D_s), .ValidD(ValidD_s), .FetchCnt(FetchCnt_s),
    .StallCnt(StallCnt_s), .FlushCnt(FlushCnt_s)
  );

  typedef struct {
    logic        sf, sd, fd, bt;
    logic [31:0] alu;
    logic        pw;
    logic [31:0] res;
    logic [31:0] pcf, pcd;
    logic        vd;
    int          fc, sc, flc;
  } vec_t;

  vec_t tbl[17];
  vec_t exp_q[$];
  int tests = 0;
  int fails = 0;

  function automatic vec_t mk(logic sf, logic sd, logic fd, logic bt, logic [31:0] alu,
                              logic pw, logic [31:0] res, logic [31:0] pcf,
                              logic [31:0] pcd, logic vd, int fc, int sc, int flc);
    vec_t v;
    v.sf = sf; v.sd = sd; v.fd = fd; v.bt = bt; v.alu = alu; v.pw = pw; v.res = res;
    v.pcf = pcf; v.pcd = pcd; v.vd = vd; v.fc = fc; v.sc = sc; v.flc = flc;
    return v;
  endfunction

  function automatic logic [31:0] sat3(int n);
    return (n > 3) ? 32'd3 : 32'(n);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
    end
  endtask

  initial begin
    vec_t e;
    logic [31:0] exp_instr;

    //           sf sd fd bt alu           pw res            pcf            pcd            vd fc sc flc
    tbl[0]  = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,         32'h4,         32'h0,         1, 1, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,         32'h8,         32'h4,         1, 2, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,         32'hC,         32'h8,         1, 3, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,         32'h10,        32'hC,         1, 4, 0, 0);
    tbl[4]  = mk(1, 1, 0, 0, 32'h0,        0, 32'h0,         32'h10,        32'hC,         1, 4, 1, 0);
    tbl[5]  = mk(1, 1, 0, 0, 32'h0,        0, 32'h0,         32'h10,        32'hC,         1, 4, 2, 0);
    tbl[6]  = mk(1, 0, 1, 1, 32'h100,      0, 32'h0,         32'h100,       32'h0,         0, 5, 2, 1);
    tbl[7]  = mk(0, 0, 0, 1, 32'h200,      1, 32'h300,       32'h200,       32'h100,       1, 6, 2, 1);
    tbl[8]  = mk(0, 0, 0, 0, 32'h0,        1, 32'h300,       32'h300,       32'h200,       1, 7, 2, 1);
    tbl[9]  = mk(0, 1, 1, 0, 32'h0,        0, 32'h0,         32'h304,       32'h0,         0, 8, 2, 2);
    tbl[10] = mk(0, 1, 0, 0, 32'h0,        0, 32'h0,         32'h308,       32'h0,         0, 9, 2, 2);
    tbl[11] = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,         32'h30C,       32'h308,       1, 10, 2, 2);
    tbl[12] = mk(0, 0, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h30C,       1, 11, 2, 2);
    tbl[13] = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,         32'h0,         32'hFFFF_FFFC, 1, 12, 2, 2);
    tbl[14] = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,         32'h4,         32'h0,         1, 13, 2, 2);
    tbl[15] = mk(1, 0, 0, 0, 32'h0,        1, 32'h40,        32'h40,        32'h4,         1, 14, 2, 2);
    tbl[16] = mk(1, 0, 0, 0, 32'h0,        0, 32'h0,         32'h40,        32'h40,        1, 14, 3, 2);

    // Reset state, sampled between edges while reset is held.
    #12;
    chk("reset_PCF",      0, PCF, 32'h0);
    chk("reset_InstrD",   0, InstrD, 32'h0);
    chk("reset_PCD",      0, PCD, 32'h0);
    chk("reset_PCPlus8D", 0, PCPlus8D, 32'h8);
    chk("reset_ValidD",   0, 32'(ValidD), 32'h0);
    chk("reset_FetchCnt", 0, 32'(FetchCnt), 32'h0);
    chk("reset_StallCnt", 0, 32'(StallCnt), 32'h0);
    chk("reset_FlushCnt", 0, 32'(FlushCnt), 32'h0);
    chk("reset_PCF_s",    0, PCF_s, 32'h80);

    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      StallF = tbl[i].sf; StallD = tbl[i].sd; FlushD = tbl[i].fd;
      BranchTakenE = tbl[i].bt; ALUResultE = tbl[i].alu;
      PCSrcW = tbl[i].pw; ResultW = tbl[i].res;
      exp_q.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      exp_instr = e.vd ? (e.pcd ^ IKEY) : 32'h0;
      chk("PCF",        i, PCF, e.pcf);
      chk("PCD",        i, PCD, e.pcd);
      chk("InstrD",     i, InstrD, exp_instr);
      chk("PCPlus8D",   i, PCPlus8D, e.pcd + 32'h8);
      chk("ValidD",     i, 32'(ValidD), 32'(e.vd));
      chk("FetchCnt",   i, 32'(FetchCnt), 32'(e.fc));
      chk("StallCnt",   i, 32'(StallCnt), 32'(e.sc));
      chk("FlushCnt",   i, 32'(FlushCnt), 32'(e.flc));
      chk("FetchCnt_s", i, 32'(FetchCnt_s), sat3(e.fc));
      chk("StallCnt_s", i, 32'(StallCnt_s), sat3(e.sc));
      chk("FlushCnt_s", i, 32'(FlushCnt_s), sat3(e.flc));
      @(negedge clk);
    end

    // Redirect, then asynchronous reset asserted mid-cycle.
    StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcW = 1'b0;
    BranchTakenE = 1'b1; ALUResultE = 32'h500;
    @(posedge clk);
    #1;
    chk("redir_PCF", 100, PCF, 32'h500);
    #2;
    reset = 1'b1;
    #1;
    chk("async_PCF",      101, PCF, 32'h0);
    chk("async_ValidD",   101, 32'(ValidD), 32'h0);
    chk("async_InstrD",   101, InstrD, 32'h0);
    chk("async_PCD",      101, PCD, 32'h0);
    chk("async_FetchCnt", 101, 32'(FetchCnt), 32'h0);
    chk("async_StallCnt", 101, 32'(StallCnt), 32'h0);
    chk("async_FlushCnt", 101, 32'(FlushCnt), 32'h0);
    chk("async_PCF_s",    101, PCF_s, 32'h80);
    chk("async_FetchCnt_s", 101, 32'(FetchCnt_s), 32'h0);
    BranchTakenE = 1'b0; ALUResultE = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_PCF",      102, PCF, 32'h4);
    chk("post_PCD",      102, PCD, 32'h0);
    chk("post_ValidD",   102, 32'(ValidD), 32'h1);
    chk("post_InstrD",   102, InstrD, IKEY);
    chk("post_FetchCnt", 102, 32'(FetchCnt), 32'h1);
    chk("post_PCF_s",    102, PCF_s, 32'h84);
    chk("post_PCD_s",    102, PCD_s, 32'h80);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
